// File: rtl/mem_wb_pipe_reg_if.sv
// ============================================================================
// Module   : mem_wb_pipe_reg_if
// Brief    : MEM->WB handshake and payload bus (upstream In_*, downstream Out_*)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_wb_pipe_reg_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
);
  logic              In_Valid;
  logic              In_Ready;
  logic [PC_W-1:0]   PC_In;
  logic              WB_EN_In;
  logic              MEM_R_EN_In;
  logic [DATA_W-1:0] ALU_Res_In;
  logic [DATA_W-1:0] Data_In;
  logic [DEST_W-1:0] Dest_In;

  logic              Out_Valid;
  logic              Out_Ready;
  logic [PC_W-1:0]   PC_Out;
  logic              WB_EN_Out;
  logic              MEM_R_EN_Out;
  logic [DATA_W-1:0] ALU_Res_Out;
  logic [DATA_W-1:0] Data_Out;
  logic [DEST_W-1:0] Dest_Out;

  modport master (
    output In_Valid, PC_In, WB_EN_In, MEM_R_EN_In, ALU_Res_In, Data_In, Dest_In,
    output Out_Ready,
    input  In_Ready,
    input  Out_Valid, PC_Out, WB_EN_Out, MEM_R_EN_Out, ALU_Res_Out, Data_Out, Dest_Out
  );

  modport slave (
    input  In_Valid, PC_In, WB_EN_In, MEM_R_EN_In, ALU_Res_In, Data_In, Dest_In,
    input  Out_Ready,
    output In_Ready,
    output Out_Valid, PC_Out, WB_EN_Out, MEM_R_EN_Out, ALU_Res_Out, Data_Out, Dest_Out
  );
endinterface

`default_nettype wire

// File: rtl/mem_wb_pipe_reg.sv
// ============================================================================
// Module   : mem_wb_pipe_reg
// Brief    : Elastic MEM->WB pipeline register with 2-entry skid buffer,
//            synchronous flush and bubble-gated WB_EN.
//            Optional macro MEM_WB_STALL_CNT_EN adds a saturating Stall_Cnt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_wb_pipe_reg #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  wire logic          CLK,
  input  wire logic          RST,
  input  wire logic          FLUSH,
  mem_wb_pipe_reg_if.slave   bus
`ifdef MEM_WB_STALL_CNT_EN
  ,
  output logic [31:0]        Stall_Cnt
`endif
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
  } payload_t;

  // State bits double as the slot valids: bit1 = skid_valid, bit0 = main_valid.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_t;

  state_t   state_q, state_d;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;

  logic     w_main_valid;
  logic     w_skid_valid;
  logic     w_accept;
  logic     w_consume;
  payload_t w_in_pay;

  assign w_main_valid = state_q[0];
  assign w_skid_valid = state_q[1];
  assign w_accept     = bus.In_Valid & ~w_skid_valid;
  assign w_consume    = w_main_valid & bus.Out_Ready;
  assign w_in_pay     = {bus.PC_In, bus.WB_EN_In, bus.MEM_R_EN_In,
                         bus.ALU_Res_In, bus.Data_In, bus.Dest_In};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FLUSH) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_accept) begin
            main_d  = w_in_pay;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_consume) begin
            main_d = w_in_pay;
          end else if (w_accept) begin
            skid_d  = w_in_pay;
            state_d = S_FULL;
          end else if (w_consume) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_consume) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.In_Ready     = ~w_skid_valid;
  assign bus.Out_Valid    = w_main_valid;
  assign bus.PC_Out       = main_q.pc;
  assign bus.WB_EN_Out    = main_q.wb_en & w_main_valid;
  assign bus.MEM_R_EN_Out = main_q.mem_r_en;
  assign bus.ALU_Res_Out  = main_q.alu_res;
  assign bus.Data_Out     = main_q.data;
  assign bus.Dest_Out     = main_q.dest;

`ifdef MEM_WB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts refused offers; deliberately independent of FLUSH.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.In_Valid && w_skid_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_pipe_reg.sv
// ============================================================================
// Module   : tb_mem_wb_pipe_reg
// Brief    : Scoreboard bench for mem_wb_pipe_reg with directed vectors
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_pipe_reg;

  logic CLK;
  logic RST;
  logic FLUSH;
`ifdef MEM_WB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  mem_wb_pipe_reg_if #(.PC_W(32), .DATA_W(32), .DEST_W(4)) bus ();

  mem_wb_pipe_reg #(.PC_W(32), .DATA_W(32), .DEST_W(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .FLUSH (FLUSH),
    .bus   (bus)
`ifdef MEM_WB_STALL_CNT_EN
    ,
    .Stall_Cnt (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        wb;
    logic        mr;
    logic [31:0] alu;
    logic [31:0] data;
    logic [3:0]  dest;
  } ent_t;

  ent_t sb[$];
  ent_t mon_exp;
  ent_t mon_act;
  int   checks = 0;
  int   errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic wb, input logic mr,
                              input logic [3:0] dest);
    ent_t e;
    e.pc   = pc;
    e.wb   = wb;
    e.mr   = mr;
    e.alu  = pc + 32'h0000_1000;
    e.data = pc ^ 32'hA5A5_0000;
    e.dest = dest;
    return e;
  endfunction

  task automatic drive(input ent_t e, input bit push);
    bus.In_Valid    = 1'b1;
    bus.PC_In       = e.pc;
    bus.WB_EN_In    = e.wb;
    bus.MEM_R_EN_In = e.mr;
    bus.ALU_Res_In  = e.alu;
    bus.Data_In     = e.data;
    bus.Dest_In     = e.dest;
    if (push) sb.push_back(e);
  endtask

  // Monitor: every consumed head entry is popped from the scoreboard and compared.
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (bus.Out_Valid === 1'b1 && bus.Out_Ready === 1'b1) begin
        mon_act = {bus.PC_Out, bus.WB_EN_Out, bus.MEM_R_EN_Out,
                   bus.ALU_Res_Out, bus.Data_Out, bus.Dest_Out};
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got pc %0h expected no entry", bus.PC_Out);
        end else begin
          mon_exp = sb.pop_front();
          chk("out_entry", mon_act, mon_exp);
        end
      end else if (bus.Out_Valid !== 1'b1) begin
        chk("bubble_wb_en", {127'd0, bus.WB_EN_Out}, 128'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST           = 1'b0;
    FLUSH         = 1'b0;
    bus.Out_Ready = 1'b1;
    drive(mk(32'hDEAD_BEEF, 1'b1, 1'b1, 4'd9), 1'b0);

    // Reset with In_Valid high
    repeat (3) @(negedge CLK);
    chk("rst_out_valid", {127'd0, bus.Out_Valid}, 128'd0);
    chk("rst_wb_en",     {127'd0, bus.WB_EN_Out}, 128'd0);
    chk("rst_in_ready",  {127'd0, bus.In_Ready}, 128'd1);
    chk("rst_data_outs", {bus.PC_Out, bus.MEM_R_EN_Out, bus.ALU_Res_Out,
                          bus.Data_Out, bus.Dest_Out}, 128'd0);
`ifdef MEM_WB_STALL_CNT_EN
    chk("rst_stall_cnt", {96'd0, stall_cnt}, 128'd0);
`endif
    RST          = 1'b1;
    bus.In_Valid = 1'b0;

    // First entry after reset: 1-cycle latency
    step();
    drive(mk(32'h100, 1'b1, 1'b0, 4'd1), 1'b1);
    step();
    bus.In_Valid = 1'b0;
    chk("lat_out_valid", {127'd0, bus.Out_Valid}, 128'd1);
    chk("lat_pc",        {96'd0, bus.PC_Out}, 128'h100);

    // Streaming at full throughput
    step();
    drive(mk(32'h10, 1'b1, 1'b1, 4'd2), 1'b1);
    step();
    chk("str_pc0", {96'd0, bus.PC_Out}, 128'h10);
    drive(mk(32'h14, 1'b1, 1'b0, 4'd3), 1'b1);
    step();
    chk("str_pc1", {96'd0, bus.PC_Out}, 128'h14);
    chk("str_in_ready", {127'd0, bus.In_Ready}, 128'd1);
    drive(mk(32'h18, 1'b1, 1'b1, 4'd4), 1'b1);
    step();
    bus.In_Valid = 1'b0;
    chk("str_pc2", {96'd0, bus.PC_Out}, 128'h18);
    chk("str_valid", {127'd0, bus.Out_Valid}, 128'd1);
    step();

    // Back-pressure fills the skid slot
    bus.Out_Ready = 1'b0;
    drive(mk(32'h20, 1'b0, 1'b1, 4'd6), 1'b1);
    step();
    chk("bp_in_ready1", {127'd0, bus.In_Ready}, 128'd1);
    drive(mk(32'h24, 1'b1, 1'b0, 4'd7), 1'b1);
    step();
    bus.In_Valid = 1'b0;
    chk("bp_in_ready0", {127'd0, bus.In_Ready}, 128'd0);
    step();
    step();
    chk("bp_hold_pc", {96'd0, bus.PC_Out}, 128'h20);
    chk("bp_hold_rdy", {127'd0, bus.In_Ready}, 128'd0);
    bus.Out_Ready = 1'b1;
    step();
    chk("bp_rdy_back", {127'd0, bus.In_Ready}, 128'd1);
    chk("bp_pc_next", {96'd0, bus.PC_Out}, 128'h24);
    step();
    chk("bp_drained", {127'd0, bus.Out_Valid}, 128'd0);

    // Flush while FULL with a concurrent offer
    bus.Out_Ready = 1'b0;
    drive(mk(32'h30, 1'b1, 1'b0, 4'd8), 1'b1);
    step();
    drive(mk(32'h34, 1'b1, 1'b0, 4'd9), 1'b1);
    step();
    drive(mk(32'h38, 1'b1, 1'b0, 4'd10), 1'b0);
    FLUSH = 1'b1;
    sb.delete();
    step();
    FLUSH        = 1'b0;
    bus.In_Valid = 1'b0;
    chk("fl_out_valid", {127'd0, bus.Out_Valid}, 128'd0);
    chk("fl_wb_en",     {127'd0, bus.WB_EN_Out}, 128'd0);
    chk("fl_in_ready",  {127'd0, bus.In_Ready}, 128'd1);
    bus.Out_Ready = 1'b1;
    repeat (3) step();
    chk("fl_no_38", {127'd0, bus.Out_Valid}, 128'd0);
`ifdef MEM_WB_STALL_CNT_EN
    chk("fl_stall_cnt", {96'd0, stall_cnt}, 128'd1);
`endif

    // Bubble gating: WB_EN_Out for exactly one cycle, Dest_Out kept
    drive(mk(32'h40, 1'b1, 1'b0, 4'd5), 1'b1);
    step();
    bus.In_Valid = 1'b0;
    chk("bub_wb_on",  {127'd0, bus.WB_EN_Out}, 128'd1);
    chk("bub_dest_1", {124'd0, bus.Dest_Out}, 128'd5);
    step();
    chk("bub_wb_off", {127'd0, bus.WB_EN_Out}, 128'd0);
    chk("bub_dest_2", {124'd0, bus.Dest_Out}, 128'd5);

`ifdef MEM_WB_STALL_CNT_EN
    // Stall counter: 7 refused cycles, then flush leaves it alone
    bus.Out_Ready = 1'b0;
    drive(mk(32'h50, 1'b1, 1'b0, 4'd1), 1'b1);
    step();
    drive(mk(32'h54, 1'b1, 1'b0, 4'd2), 1'b1);
    step();
    drive(mk(32'h58, 1'b1, 1'b0, 4'd3), 1'b0);
    repeat (7) step();
    chk("cnt_seven", {96'd0, stall_cnt}, 128'd8);
    bus.In_Valid = 1'b0;
    FLUSH = 1'b1;
    sb.delete();
    step();
    FLUSH = 1'b0;
    step();
    chk("cnt_after_flush", {96'd0, stall_cnt}, 128'd8);
    bus.Out_Ready = 1'b1;
`endif

    // Asynchronous reset mid-transfer
    bus.Out_Ready = 1'b0;
    drive(mk(32'h60, 1'b1, 1'b1, 4'd11), 1'b1);
    step();
    drive(mk(32'h64, 1'b1, 1'b1, 4'd12), 1'b1);
    step();
    bus.In_Valid = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    chk("arst_out_valid", {127'd0, bus.Out_Valid}, 128'd0);
    chk("arst_in_ready",  {127'd0, bus.In_Ready}, 128'd1);
    chk("arst_pc",        {96'd0, bus.PC_Out}, 128'd0);
    sb.delete();
    @(negedge CLK);
    RST           = 1'b1;
    bus.Out_Ready = 1'b1;
    repeat (3) step();

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
